// File: rtl/div_unit_param_if.sv
// Request/result handshake between the execute stage and the iterative divider.
interface div_unit_param_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             start_i;
    logic             annul_i;
    logic [1:0]       op_i;
    logic             word_i;
    logic [XLEN-1:0]  opdata1_i;
    logic [XLEN-1:0]  opdata2_i;
    logic [TAG_W-1:0] tag_i;
    logic             busy_o;
    logic             valid_o;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output start_i, annul_i, op_i, word_i, opdata1_i, opdata2_i, tag_i,
        input  busy_o, valid_o, result_o, tag_o
    );

    modport slave (
        input  start_i, annul_i, op_i, word_i, opdata1_i, opdata2_i, tag_i,
        output busy_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/div_unit_param.sv
// Radix-2 restoring integer divider with RISC-V M-extension result rules.
// state | meaning
// IDLE  | waiting for a request; result/tag outputs hold the last result
// CALC  | one quotient bit per cycle on operand magnitudes
// FIX   | apply signs, div-by-zero and word-mode rules, then strobe valid
module div_unit_param #(
    parameter int XLEN     = 64,
    parameter int HAS_WORD = 1,
    parameter int TAG_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    div_unit_param_if.slave bus
);
    localparam bit WORD_EN = (HAS_WORD != 0) && (XLEN == 64);
    localparam int CNT_W   = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_fire;

    logic [XLEN-1:0]  r_dq;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_word;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [TAG_W-1:0] r_tag;

    logic             r_valid;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag_o;

    logic             w_word;
    logic             w_signed;
    logic [XLEN-1:0]  w_a_sx;
    logic [XLEN-1:0]  w_a_zx;
    logic [XLEN-1:0]  w_b_sx;
    logic [XLEN-1:0]  w_b_zx;
    logic [XLEN-1:0]  w_a_eff;
    logic [XLEN-1:0]  w_b_eff;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic             w_b_zero;
    logic [XLEN-1:0]  w_dq_load;

    logic [XLEN:0]    w_trial;
    logic             w_qbit;
    logic [CNT_W-1:0] w_last;

    logic [XLEN-1:0]  w_q_f;
    logic [XLEN-1:0]  w_r_f;
    logic [XLEN-1:0]  w_sel;
    logic [XLEN-1:0]  w_sel_sx;
    logic [XLEN-1:0]  w_result;

    // Operand preparation: effective-width operands and their magnitudes.
    assign w_word   = WORD_EN && bus.word_i;
    assign w_signed = ~bus.op_i[0];
    assign w_a_sx   = XLEN'($signed(bus.opdata1_i[31:0]));
    assign w_a_zx   = XLEN'(bus.opdata1_i[31:0]);
    assign w_b_sx   = XLEN'($signed(bus.opdata2_i[31:0]));
    assign w_b_zx   = XLEN'(bus.opdata2_i[31:0]);
    assign w_a_eff  = w_word ? (w_signed ? w_a_sx : w_a_zx) : bus.opdata1_i;
    assign w_b_eff  = w_word ? (w_signed ? w_b_sx : w_b_zx) : bus.opdata2_i;
    assign w_a_neg  = w_signed & w_a_eff[XLEN-1];
    assign w_b_neg  = w_signed & w_b_eff[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_eff : w_a_eff;
    assign w_b_mag  = w_b_neg ? -w_b_eff : w_b_eff;
    assign w_b_zero = (w_b_eff == '0);

    // Word-mode dividends are left-aligned so CALC always consumes from the MSB;
    // on divide-by-zero the raw dividend is parked here for the remainder.
    assign w_dq_load = w_b_zero ? w_a_eff
                     : (w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag);

    assign w_trial = {r_rem, r_dq[XLEN-1]} - {1'b0, r_dvs};
    assign w_qbit  = ~w_trial[XLEN];
    assign w_last  = r_word ? CNT_W'(31) : CNT_W'(XLEN - 1);

    assign w_q_f    = r_dz ? '1 : (r_neg_q ? -r_dq : r_dq);
    assign w_r_f    = r_dz ? r_dq : (r_neg_r ? -r_rem : r_rem);
    assign w_sel    = r_is_rem ? w_r_f : w_q_f;
    assign w_sel_sx = XLEN'($signed(w_sel[31:0]));
    assign w_result = r_word ? w_sel_sx : w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_b_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.annul_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == w_last) begin
                        w_state_nxt = S_FIX;
                    end
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                if (!bus.annul_i) begin
                    w_fire = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dq     <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_word   <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_dq     <= w_dq_load;
            r_rem    <= '0;
            r_dvs    <= w_b_mag;
            r_cnt    <= '0;
            r_word   <= w_word;
            r_is_rem <= bus.op_i[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= w_b_zero;
            r_tag    <= bus.tag_i;
        end else if (w_step) begin
            r_dq  <= {r_dq[XLEN-2:0], w_qbit};
            r_rem <= w_qbit ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_dq[XLEN-1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag_o  <= '0;
        end else begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_result <= w_result;
                r_tag_o  <= r_tag;
            end
        end
    end

    assign bus.busy_o   = (r_state != S_IDLE);
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;
    assign bus.tag_o    = r_tag_o;
endmodule

// File: tb/tb_div_unit_param.sv
// Directed-vector bench for div_unit_param at XLEN=64 with word mode enabled.
module tb_div_unit_param;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [63:0] last_res;
    int   lat;
    bit   seen;

    div_unit_param_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_unit_param #(.XLEN(XLEN), .HAS_WORD(1), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drives a one-cycle request; returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.word_i    = word;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.tag_i     = tag;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (n < bound && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.valid_o) got = 1'b1;
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input int exp_lat);
        int  n;
        bit  got;
        issue(op, word, a, b, tag);
        chk({name, "_busy"}, 64'(bus.busy_o), 64'd1);
        chk({name, "_vpulse"}, 64'(bus.valid_o), 64'd0);
        wait_valid(200, n, got);
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_res"}, bus.result_o, exp);
        chk({name, "_tag"}, 64'(bus.tag_o), 64'(tag));
        chk({name, "_idle"}, 64'(bus.busy_o), 64'd0);
        last_res = exp;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        last_res = '0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.op_i = 2'b00;
        bus.word_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.tag_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_res", bus.result_o, 64'd0);
        chk("rst_tag", 64'(bus.tag_o), 64'd0);
        rst = 1'b0;

        do_op("divu", 2'b01, 1'b0, 64'd100, 64'd7, 5'h1A, 64'd14, 65);
        do_op("remu", 2'b11, 1'b0, 64'd100, 64'd7, 5'h1A, 64'd2, 65);
        do_op("div_n7_2", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h01, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("rem_n7_2", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h02, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        do_op("div_7_n2", 2'b00, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'h03, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("rem_7_n2", 2'b10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'h04, 64'd1, 65);
        do_op("div_dz", 2'b00, 1'b0, 64'd5, 64'd0, 5'h05, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remu_dz", 2'b11, 1'b0, 64'd5, 64'd0, 5'h06, 64'd5, 1);
        do_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h07, 64'h8000_0000_0000_0000, 65);
        do_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h08, 64'd0, 65);
        do_op("divw", 2'b00, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'h09, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        do_op("divuw", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'h0A, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        do_op("remw_dz", 2'b10, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0000, 5'h0B, 64'hFFFF_FFFF_8000_0000, 1);
        do_op("remuw", 2'b11, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h1_0000_0007, 5'h0C, 64'd2, 33);

        // Start while busy must be ignored.
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'h11);
        repeat (5) @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.opdata1_i = 64'd50;
        bus.opdata2_i = 64'd5;
        bus.tag_i = 5'h12;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_valid(200, lat, seen);
        chk("busy_start_lat", 64'(lat + 6), 64'd65);
        chk("busy_start_res", bus.result_o, 64'd14);
        chk("busy_start_tag", 64'(bus.tag_o), 64'h11);
        last_res = 64'd14;

        // Annul in CALC.
        issue(2'b01, 1'b0, 64'd1000, 64'd3, 5'h13);
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        chk("annul_busy", 64'(bus.busy_o), 64'd0);
        chk("annul_valid", 64'(bus.valid_o), 64'd0);
        wait_valid(80, lat, seen);
        chk("annul_novalid", 64'(seen), 64'd0);
        chk("annul_res_hold", bus.result_o, last_res);
        do_op("divu_9_3", 2'b01, 1'b0, 64'd9, 64'd3, 5'h14, 64'd3, 65);

        // Annul together with start in IDLE drops the request.
        bus.annul_i = 1'b1;
        issue(2'b01, 1'b0, 64'd9, 64'd3, 5'h15);
        bus.annul_i = 1'b0;
        chk("annul_idle_busy", 64'(bus.busy_o), 64'd0);

        // Reset mid-calculation.
        issue(2'b00, 1'b0, 64'd77, 64'd7, 5'h16);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy_o), 64'd0);
        chk("midrst_valid", 64'(bus.valid_o), 64'd0);
        chk("midrst_res", bus.result_o, 64'd0);
        chk("midrst_tag", 64'(bus.tag_o), 64'd0);
        wait_valid(80, lat, seen);
        chk("midrst_novalid", 64'(seen), 64'd0);
        do_op("post_rst", 2'b00, 1'b0, 64'd77, 64'd7, 5'h17, 64'd11, 65);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/div_unit_param.md
Name: div_unit_param

Overview:
- Parametrised multi-cycle radix-2 restoring integer divider for the execute stage.
- Generalises the fixed 64-bit divider to XLEN-bit operands.
- Adds full RISC-V M-extension result semantics: DIV/DIVU/REM/REMU, plus W-variants when XLEN=64.
- Single result per operation, a tag passthrough, and a valid/busy handshake with annul.

Parameters:
- XLEN, 64, operand and result width (32 or 64).
- HAS_WORD, 1, enables the 32-bit word-mode ops (DIVW etc.); forced inactive when XLEN=32.
- TAG_W, 5, width of the opaque tag (e.g. rd index) carried from start to result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only in IDLE with annul_i=0.
- annul_i  input  1  kill the in-flight op (pipeline flush).
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- word_i  input  1  word mode; honoured only if HAS_WORD=1 and XLEN=64.
- opdata1_i  input  XLEN  dividend.
- opdata2_i  input  XLEN  divisor.
- tag_i  input  TAG_W  request tag.
- busy_o  output  1  high whenever state != IDLE.
- valid_o  output  1  one-cycle result strobe.
- result_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- tag_o  output  TAG_W  tag of the op being returned.

Behaviour:
- Reset: state=IDLE; valid_o=0; busy_o=0; result_o=0; tag_o=0; all internal registers cleared. Reset mid-operation aborts it; no valid_o is produced.
- States: IDLE, CALC, FIX.
- IDLE: on start_i=1 and annul_i=0, latch op, word, tag, and the result-negate and remainder-negate flags.
  - signed = op_i[0]==0.
  - Word mode uses the low 32 bits of each operand, sign-extended if signed, zero-extended otherwise.
  - Dividend and divisor are latched as magnitudes (two's-complement negate when signed and negative); the most-negative value's magnitude is held as unsigned 2^(N-1).
  - N = 32 in word mode, else XLEN; cnt=0.
  - Divisor == 0 (in the effective width): go directly to FIX with the div-by-zero flag set.
  - Otherwise go to CALC.
  - start_i outside IDLE is ignored.
- CALC: one restoring step per cycle, N cycles.
  - Trial = {partial remainder, next dividend bit} - divisor.
  - Non-negative trial: keep it and shift in quotient bit 1; otherwise shift in 0.
  - After the N-th step, go to FIX.
- FIX (1 cycle):
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - Div-by-zero: quotient = all ones; remainder = original dividend (effective width).
  - Overflow (signed min / -1) falls out of the magnitude path: quotient = min, remainder = 0.
  - Word mode: the 32-bit result is sign-extended to XLEN, for both signed and unsigned ops.
  - Registers result_o and tag_o, sets valid_o=1, goes to IDLE.
- valid_o is high exactly one cycle; result_o and tag_o hold until the next valid.
- Latency, counted as edges from the accepting edge to the edge that raises valid_o:
  - Normal op: N+1 (65 for XLEN=64, 33 in word mode).
  - Div-by-zero: 1.
- Back-to-back: a start in the cycle valid_o is high is accepted, since state is IDLE.
- annul_i=1 in CALC or FIX: next state IDLE, valid_o stays 0, result_o unchanged. annul_i with start_i in IDLE: the request is dropped.
- busy_o is derived combinationally from state. It falls on the same edge that raises valid_o, or the edge after annul_i.

Test Plan:
1. XLEN=64. DIVU 100/7 → result 14 with valid_o exactly 65 edges after accept; REMU 100/7 → 2; tag 0x1A echoed on tag_o.
2. DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF; DIV 7/-2 → -3; REM 7/-2 → 1.
3. DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 → 5; each with valid_o 1 edge after accept and busy_o high for one cycle.
4. DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM of the same operands → 0.
5. Word mode:
   - DIVW opdata1=0x0000_0001_FFFF_FFF9, opdata2=2 → 0xFFFF_FFFF_FFFF_FFFD, latency 33.
   - DIVUW 0xFFFF_FFFE/1 → 0xFFFF_FFFF_FFFF_FFFE.
   - REMW x/0 with low 32 bits 0x8000_0000 → 0xFFFF_FFFF_8000_0000.
6. Handshake and abort:
   - start while busy is ignored (result belongs to the first op).
   - annul_i at CALC cycle 10 → no valid_o, busy_o low next cycle, then a new DIVU 9/3 → 3.
   - rst at CALC cycle 20 → all outputs 0, no valid_o.
   - Back-to-back start on the valid_o cycle is accepted.
